// File: rtl/surf_cmd_pkg.sv
// Shared definitions for the SURF v4 command link: frame TYPE codes, receiver FSM states and
// a constant-foldable clog2 used to size buffer-index and bit-counter fields.
package surf_cmd_pkg;

    localparam logic [1:0] CMD_SAMPLE   = 2'b00;
    localparam logic [1:0] CMD_DIGITIZE = 2'b01;
    localparam logic [1:0] CMD_CLEAR    = 2'b10;
    localparam logic [1:0] CMD_RSVD     = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StType,
        StBuf,
        StId,
        StPar
    } cmd_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/surf_command_receiver_v4_if.sv
// Receiver-side bundle: serial command line in, decoded pulses and held event-ID fields out.
interface surf_command_receiver_v4_if
    import surf_cmd_pkg::*;
#(
    parameter int unsigned ID_WIDTH    = 32,
    parameter int unsigned NUM_BUFFERS = 4
) ();

    localparam int unsigned BUF_BITS = clog2(NUM_BUFFERS);

    logic                   cmd_i;
    logic                   cmd_debug_o;
    logic                   sample_o;
    logic [NUM_BUFFERS-1:0] digitize_o;
    logic [NUM_BUFFERS-1:0] clear_o;
    logic                   event_id_wr_o;
    logic                   event_id_ok_o;
    logic [BUF_BITS-1:0]    event_id_buffer_o;
    logic [ID_WIDTH-1:0]    event_id_o;
    logic                   frame_err_o;
    logic [7:0]             err_count_o;

    modport slave (
        input  cmd_i,
        output cmd_debug_o, sample_o, digitize_o, clear_o, event_id_wr_o, event_id_ok_o,
               event_id_buffer_o, event_id_o, frame_err_o, err_count_o
    );

    modport master (
        output cmd_i,
        input  cmd_debug_o, sample_o, digitize_o, clear_o, event_id_wr_o, event_id_ok_o,
               event_id_buffer_o, event_id_o, frame_err_o, err_count_o
    );

endinterface

// File: rtl/surf_cmd_deser.sv
// Shared payload deserialiser: a down-counter reloaded per field and a shift register whose
// output already includes the bit being sampled this cycle.
module surf_cmd_deser #(
    parameter int unsigned ID_WIDTH = 32,
    parameter int unsigned CNT_W    = 6
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [CNT_W-1:0]    load_cnt_i,
    input  logic                shift_i,
    input  logic                bit_i,
    output logic                done_o,
    output logic [ID_WIDTH-1:0] field_o
);

    logic [CNT_W-1:0]    cnt_q;
    logic [ID_WIDTH-2:0] sh_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            if (load_i) begin
                cnt_q <= load_cnt_i;
            end else if (shift_i && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (shift_i) begin
                sh_q <= {sh_q[ID_WIDTH-3:0], bit_i};
            end
        end
    end

    // done marks the cycle whose incoming bit is the last of the current field
    assign done_o  = (cnt_q == CNT_W'(1));
    assign field_o = {sh_q, bit_i};

endmodule

// File: rtl/surf_command_receiver_v4.sv
// SURF serial command receiver: decodes SAMPLE / DIGITIZE / CLEAR frames into registered
// one-cycle pulses, checks DIGITIZE parity and keeps a saturating frame-error count.
module surf_command_receiver_v4
    import surf_cmd_pkg::*;
#(
    parameter int unsigned ID_WIDTH    = 32,
    parameter int unsigned NUM_BUFFERS = 4,
    parameter int unsigned IN_REG      = 0
) (
    input logic                      clk33_i,
    input logic                      rst_i,
    surf_command_receiver_v4_if.slave bus_io
);

    localparam int unsigned BUF_BITS = clog2(NUM_BUFFERS);
    localparam int unsigned CNT_W    = clog2(ID_WIDTH + 1);
    localparam logic [NUM_BUFFERS-1:0] BUF_ONE = NUM_BUFFERS'(1);

    logic cmd_s;

    generate
        if (IN_REG != 0) begin : g_in_reg
            logic cmd_q;
            always_ff @(posedge clk33_i or posedge rst_i) begin
                if (rst_i) cmd_q <= 1'b0;
                else       cmd_q <= bus_io.cmd_i;
            end
            assign cmd_s = cmd_q;
        end else begin : g_no_in_reg
            assign cmd_s = bus_io.cmd_i;
        end
    endgenerate

    cmd_state_e             state_q;
    logic [1:0]             typ_q;
    logic [BUF_BITS-1:0]    buf_q;
    logic [ID_WIDTH-1:0]    id_cap_q;

    logic                   sample_q;
    logic [NUM_BUFFERS-1:0] digitize_q;
    logic [NUM_BUFFERS-1:0] clear_q;
    logic                   wr_q;
    logic                   ok_q;
    logic [BUF_BITS-1:0]    ev_buf_q;
    logic [ID_WIDTH-1:0]    ev_id_q;
    logic                   ferr_q;
    logic [7:0]             err_cnt_q;

    logic                   ld;
    logic [CNT_W-1:0]       ld_cnt;
    logic                   done;
    logic [ID_WIDTH-1:0]    fld;
    logic                   err_d;
    logic                   fld_buf_ok;
    logic                   buf_q_ok;
    logic                   par_ok;

    surf_cmd_deser #(
        .ID_WIDTH (ID_WIDTH),
        .CNT_W    (CNT_W)
    ) u_deser (
        .clk_i      (clk33_i),
        .rst_i      (rst_i),
        .load_i     (ld),
        .load_cnt_i (ld_cnt),
        .shift_i    (state_q != StIdle),
        .bit_i      (cmd_s),
        .done_o     (done),
        .field_o    (fld)
    );

    assign fld_buf_ok = (32'(fld[BUF_BITS-1:0]) < NUM_BUFFERS);
    assign buf_q_ok   = (32'(buf_q) < NUM_BUFFERS);
    // Even parity: BUF, ID and the parity bit together hold an even number of ones
    assign par_ok     = ~^{buf_q, id_cap_q, cmd_s};

    // Counter reloads on every state entry; errors are resolved on each field's last bit
    always_comb begin
        ld     = 1'b0;
        ld_cnt = '0;
        err_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_s) begin
                    ld     = 1'b1;
                    ld_cnt = CNT_W'(2);
                end
            end
            StType: begin
                if (done && (fld[1:0] == CMD_DIGITIZE || fld[1:0] == CMD_CLEAR)) begin
                    ld     = 1'b1;
                    ld_cnt = CNT_W'(BUF_BITS);
                end
                err_d = done && (fld[1:0] == CMD_RSVD);
            end
            StBuf: begin
                if (done && typ_q == CMD_DIGITIZE) begin
                    ld     = 1'b1;
                    ld_cnt = CNT_W'(ID_WIDTH);
                end
                err_d = done && (typ_q == CMD_CLEAR) && !fld_buf_ok;
            end
            StId: begin
                if (done) begin
                    ld     = 1'b1;
                    ld_cnt = CNT_W'(1);
                end
            end
            StPar: begin
                err_d = !buf_q_ok || !par_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk33_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            typ_q      <= '0;
            buf_q      <= '0;
            id_cap_q   <= '0;
            sample_q   <= 1'b0;
            digitize_q <= '0;
            clear_q    <= '0;
            wr_q       <= 1'b0;
            ok_q       <= 1'b0;
            ev_buf_q   <= '0;
            ev_id_q    <= '0;
            ferr_q     <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            sample_q   <= 1'b0;
            digitize_q <= '0;
            clear_q    <= '0;
            wr_q       <= 1'b0;
            ferr_q     <= err_d;
            if (err_d && err_cnt_q != 8'hff) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (cmd_s) state_q <= StType;
                end
                StType: begin
                    if (done) begin
                        unique case (fld[1:0])
                            CMD_SAMPLE: begin
                                sample_q <= 1'b1;
                                state_q  <= StIdle;
                            end
                            CMD_DIGITIZE, CMD_CLEAR: begin
                                typ_q   <= fld[1:0];
                                state_q <= StBuf;
                            end
                            CMD_RSVD: state_q <= StIdle;
                            default:  state_q <= StIdle;
                        endcase
                    end
                end
                StBuf: begin
                    if (done) begin
                        if (typ_q == CMD_CLEAR) begin
                            if (fld_buf_ok) clear_q <= BUF_ONE << fld[BUF_BITS-1:0];
                            state_q <= StIdle;
                        end else begin
                            buf_q   <= fld[BUF_BITS-1:0];
                            state_q <= StId;
                        end
                    end
                end
                StId: begin
                    if (done) begin
                        id_cap_q <= fld;
                        state_q  <= StPar;
                    end
                end
                StPar: begin
                    if (buf_q_ok) begin
                        wr_q     <= 1'b1;
                        ok_q     <= par_ok;
                        ev_buf_q <= buf_q;
                        ev_id_q  <= id_cap_q;
                        if (par_ok) digitize_q <= BUF_ONE << buf_q;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.cmd_debug_o       = (state_q != StIdle);
    assign bus_io.sample_o          = sample_q;
    assign bus_io.digitize_o        = digitize_q;
    assign bus_io.clear_o           = clear_q;
    assign bus_io.event_id_wr_o     = wr_q;
    assign bus_io.event_id_ok_o     = ok_q;
    assign bus_io.event_id_buffer_o = ev_buf_q;
    assign bus_io.event_id_o        = ev_id_q;
    assign bus_io.frame_err_o       = ferr_q;
    assign bus_io.err_count_o       = err_cnt_q;

endmodule

// File: tb/tb_surf_command_receiver_v4.sv
// Directed bench: table of frames with hand-computed outputs on the default receiver, plus
// sequences for error saturation, mid-frame reset and a NUM_BUFFERS=3/ID_WIDTH=16/IN_REG=1 build.
module tb_surf_command_receiver_v4;

    logic clk;
    logic rst;
    logic cmd_a;
    logic cmd_b;

    int n_tests;
    int n_fail;

    surf_command_receiver_v4_if #(.ID_WIDTH(32), .NUM_BUFFERS(4)) bus_a ();
    surf_command_receiver_v4_if #(.ID_WIDTH(16), .NUM_BUFFERS(3)) bus_b ();

    assign bus_a.cmd_i = cmd_a;
    assign bus_b.cmd_i = cmd_b;

    surf_command_receiver_v4 #(
        .ID_WIDTH    (32),
        .NUM_BUFFERS (4),
        .IN_REG      (0)
    ) u_dut_a (
        .clk33_i (clk),
        .rst_i   (rst),
        .bus_io  (bus_a.slave)
    );

    surf_command_receiver_v4 #(
        .ID_WIDTH    (16),
        .NUM_BUFFERS (3),
        .IN_REG      (1)
    ) u_dut_b (
        .clk33_i (clk),
        .rst_i   (rst),
        .bus_io  (bus_b.slave)
    );

    initial clk = 1'b0;
    always #15 clk = ~clk;

    logic any_pulse_a;
    assign any_pulse_a = bus_a.sample_o | (|bus_a.digitize_o) | (|bus_a.clear_o) |
                         bus_a.event_id_wr_o | bus_a.frame_err_o;

    typedef struct {
        int          gap;
        logic [63:0] bits;
        int          len;
        logic        s;
        logic [3:0]  d;
        logic [3:0]  c;
        logic        w;
        logic        ok;
        logic [1:0]  b;
        logic [31:0] id;
        logic        fe;
        logic [7:0]  cnt;
    } vec_t;

    localparam int NV = 11;
    vec_t  vec [NV];
    string vn  [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic par32(input logic [1:0] b, input logic [31:0] id);
        return ^{b, id};
    endfunction

    function automatic logic par16(input logic [1:0] b, input logic [15:0] id);
        return ^{b, id};
    endfunction

    function automatic logic [63:0] fr_sample();
        return 64'(3'b100);
    endfunction

    function automatic logic [63:0] fr_rsvd();
        return 64'(3'b111);
    endfunction

    function automatic logic [63:0] fr_clear(input logic [1:0] b);
        return 64'({1'b1, 2'b10, b});
    endfunction

    function automatic logic [63:0] fr_dig(input logic [1:0] b, input logic [31:0] id,
                                           input logic p);
        return {26'd0, 1'b1, 2'b01, b, id, p};
    endfunction

    function automatic logic [63:0] fr_dig16(input logic [1:0] b, input logic [15:0] id,
                                             input logic p);
        return 64'({1'b1, 2'b01, b, id, p});
    endfunction

    // Bits driven at negedges, MSB first; on return the final bit has just been sampled
    task automatic send(input logic [63:0] bits, input int len, input bit sel, input bit chk);
        for (int j = 0; j < len; j++) begin
            if (chk && j == len - 1) begin
                check("early_pulse", 64'(any_pulse_a), 64'd0);
                check("busy_debug", 64'(bus_a.cmd_debug_o), 64'd1);
            end
            if (sel) cmd_b = bits[len-1-j];
            else     cmd_a = bits[len-1-j];
            @(negedge clk);
            if (chk && j == 0) check("pulse_width", 64'(any_pulse_a), 64'd0);
        end
        if (sel) cmd_b = 1'b0;
        else     cmd_a = 1'b0;
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, ".debug"}, 64'(bus_a.cmd_debug_o), 64'd0);
        check({tag, ".pulses"}, 64'(any_pulse_a), 64'd0);
        check({tag, ".ok"}, 64'(bus_a.event_id_ok_o), 64'd0);
        check({tag, ".buf"}, 64'(bus_a.event_id_buffer_o), 64'd0);
        check({tag, ".id"}, 64'(bus_a.event_id_o), 64'd0);
        check({tag, ".cnt"}, 64'(bus_a.err_count_o), 64'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        cmd_a   = 1'b0;
        cmd_b   = 1'b0;

        //        gap bits                                         len s     d      c      w     ok    b     id            fe    cnt
        vn[0]  = "sample";
        vec[0]  = '{2, fr_sample(),                                3, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 8'd0};
        vn[1]  = "dig_good";
        vec[1]  = '{1, fr_dig(2'd0, 32'h12345678, 1'b1),           38, 1'b0, 4'h1, 4'h0, 1'b1, 1'b1, 2'd0, 32'h12345678, 1'b0, 8'd0};
        vn[2]  = "dig_badpar";
        vec[2]  = '{1, fr_dig(2'd0, 32'h12345678, 1'b0),           38, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 32'h12345678, 1'b1, 8'd1};
        vn[3]  = "clear3";
        vec[3]  = '{1, fr_clear(2'd3),                             5, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0, 2'd0, 32'h12345678, 1'b0, 8'd1};
        vn[4]  = "dig_b2b";
        vec[4]  = '{0, fr_dig(2'd2, 32'hDEADBEEF, par32(2'd2, 32'hDEADBEEF)),
                                                                   38, 1'b0, 4'h4, 4'h0, 1'b1, 1'b1, 2'd2, 32'hDEADBEEF, 1'b0, 8'd1};
        vn[5]  = "rsvd";
        vec[5]  = '{1, fr_rsvd(),                                  3, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 1'b1, 8'd2};
        vn[6]  = "sample_b2b";
        vec[6]  = '{0, fr_sample(),                                3, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 1'b0, 8'd2};
        vn[7]  = "dig_ones";
        vec[7]  = '{0, fr_dig(2'd1, 32'hFFFFFFFF, par32(2'd1, 32'hFFFFFFFF)),
                                                                   38, 1'b0, 4'h2, 4'h0, 1'b1, 1'b1, 2'd1, 32'hFFFFFFFF, 1'b0, 8'd2};
        vn[8]  = "dig_b3_bad";
        vec[8]  = '{3, fr_dig(2'd3, 32'h0, ~par32(2'd3, 32'h0)),   38, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd3, 32'h0,        1'b1, 8'd3};
        vn[9]  = "clear0";
        vec[9]  = '{0, fr_clear(2'd0),                             5, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 2'd3, 32'h0,        1'b0, 8'd3};
        vn[10] = "dig_b3_good";
        vec[10] = '{1, fr_dig(2'd3, 32'h80000001, 1'b0),           38, 1'b0, 4'h8, 4'h0, 1'b1, 1'b1, 2'd3, 32'h80000001, 1'b0, 8'd3};

        // Reset values
        repeat (2) @(negedge clk);
        check_a_zero("reset");
        check("reset.b_pulses", 64'(bus_b.sample_o | (|bus_b.digitize_o) | bus_b.frame_err_o),
              64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_a_zero("post_reset");

        for (int i = 0; i < NV; i++) begin
            repeat (vec[i].gap) @(negedge clk);
            send(vec[i].bits, vec[i].len, 1'b0, 1'b1);
            check({vn[i], ".sample"}, 64'(bus_a.sample_o), 64'(vec[i].s));
            check({vn[i], ".digitize"}, 64'(bus_a.digitize_o), 64'(vec[i].d));
            check({vn[i], ".clear"}, 64'(bus_a.clear_o), 64'(vec[i].c));
            check({vn[i], ".wr"}, 64'(bus_a.event_id_wr_o), 64'(vec[i].w));
            check({vn[i], ".ok"}, 64'(bus_a.event_id_ok_o), 64'(vec[i].ok));
            check({vn[i], ".buf"}, 64'(bus_a.event_id_buffer_o), 64'(vec[i].b));
            check({vn[i], ".id"}, 64'(bus_a.event_id_o), 64'(vec[i].id));
            check({vn[i], ".ferr"}, 64'(bus_a.frame_err_o), 64'(vec[i].fe));
            check({vn[i], ".cnt"}, 64'(bus_a.err_count_o), 64'(vec[i].cnt));
            check({vn[i], ".debug"}, 64'(bus_a.cmd_debug_o), 64'd0);
        end

        // Error counter saturation
        for (int k = 0; k < 300; k++) send(fr_rsvd(), 3, 1'b0, 1'b0);
        check("sat.ferr", 64'(bus_a.frame_err_o), 64'd1);
        check("sat.cnt", 64'(bus_a.err_count_o), 64'd255);
        repeat (3) @(negedge clk);
        check("sat.hold", 64'(bus_a.err_count_o), 64'd255);
        check("sat.ferr_low", 64'(bus_a.frame_err_o), 64'd0);

        // Variant build: NUM_BUFFERS=3, ID_WIDTH=16, input register adds one cycle
        repeat (2) @(negedge clk);
        send(fr_dig16(2'd3, 16'hABCD, par16(2'd3, 16'hABCD)), 22, 1'b1, 1'b0);
        check("v.oor.latency", 64'(bus_b.frame_err_o), 64'd0);
        @(negedge clk);
        check("v.oor.ferr", 64'(bus_b.frame_err_o), 64'd1);
        check("v.oor.wr", 64'(bus_b.event_id_wr_o), 64'd0);
        check("v.oor.dig", 64'(bus_b.digitize_o), 64'd0);
        check("v.oor.cnt", 64'(bus_b.err_count_o), 64'd1);
        check("v.oor.id", 64'(bus_b.event_id_o), 64'd0);
        check("v.oor.buf", 64'(bus_b.event_id_buffer_o), 64'd0);
        repeat (2) @(negedge clk);
        send(fr_dig16(2'd1, 16'h1234, par16(2'd1, 16'h1234)), 22, 1'b1, 1'b0);
        check("v.dig.latency", 64'(bus_b.digitize_o), 64'd0);
        @(negedge clk);
        check("v.dig.digitize", 64'(bus_b.digitize_o), 64'h2);
        check("v.dig.wr", 64'(bus_b.event_id_wr_o), 64'd1);
        check("v.dig.ok", 64'(bus_b.event_id_ok_o), 64'd1);
        check("v.dig.id", 64'(bus_b.event_id_o), 64'h1234);
        check("v.dig.buf", 64'(bus_b.event_id_buffer_o), 64'd1);
        check("v.dig.ferr", 64'(bus_b.frame_err_o), 64'd0);
        @(negedge clk);
        check("v.dig.width", 64'(bus_b.digitize_o), 64'd0);
        repeat (2) @(negedge clk);
        send(fr_clear(2'd3), 5, 1'b1, 1'b0);
        @(negedge clk);
        check("v.clr3.clear", 64'(bus_b.clear_o), 64'd0);
        check("v.clr3.ferr", 64'(bus_b.frame_err_o), 64'd1);
        check("v.clr3.cnt", 64'(bus_b.err_count_o), 64'd2);
        repeat (2) @(negedge clk);
        send(fr_clear(2'd2), 5, 1'b1, 1'b0);
        @(negedge clk);
        check("v.clr2.clear", 64'(bus_b.clear_o), 64'h4);
        check("v.clr2.ferr", 64'(bus_b.frame_err_o), 64'd0);

        // Reset in the middle of a DIGITIZE frame
        repeat (2) @(negedge clk);
        begin
            logic [63:0] fb;
            logic        seen;
            fb = fr_dig(2'd0, 32'h12345678, 1'b1);
            for (int j = 0; j < 20; j++) begin
                cmd_a = fb[37-j];
                @(negedge clk);
            end
            cmd_a = 1'b0;
            rst   = 1'b1;
            @(negedge clk);
            check_a_zero("midrst");
            @(negedge clk);
            rst  = 1'b0;
            seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                seen = seen | any_pulse_a | bus_a.cmd_debug_o;
            end
            check("midrst.quiet", 64'(seen), 64'd0);
            check_a_zero("midrst_after");
        end
        send(fr_sample(), 3, 1'b0, 1'b1);
        check("resync.sample", 64'(bus_a.sample_o), 64'd1);
        check("resync.ferr", 64'(bus_a.frame_err_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/surf_command_receiver_v4.md
# surf_command_receiver_v4

Parametrised serial command receiver for the SURF digitizer, clocked at 33 MHz. It decodes framed commands arriving on the single-bit command line driven by the TURF-side command interface: SAMPLE, DIGITIZE (buffer index plus event ID) and CLEAR. Beyond the v3 receiver, it generalises event-ID width and buffer count, checks parity on every DIGITIZE frame, adds a CLEAR command, and counts frame errors. It sits between the command pin and the LAB4 readout/buffer manager.

## Interface
- `ID_WIDTH`, 32, event-ID bits per DIGITIZE frame (8..32).
- `NUM_BUFFERS`, 4, number of digitizer buffers (2..8); `BUF_BITS = clog2(NUM_BUFFERS)`.
- `IN_REG`, 0, 1 = register `cmd_i` once before decode (adds 1 cycle to every latency).
- `clk33_i`  in  1  system clock; `cmd_i` is launched in this domain.
- `rst_i`  in  1  asynchronous, active-high reset.
- `cmd_i`  in  1  serial command line, idle low.
- `cmd_debug_o`  out  1  high while a frame is in progress (state ≠ IDLE).
- `sample_o`  out  1  1-cycle pulse on SAMPLE.
- `digitize_o`  out  NUM_BUFFERS  one-hot 1-cycle pulse on a good DIGITIZE.
- `clear_o`  out  NUM_BUFFERS  one-hot 1-cycle pulse on CLEAR.
- `event_id_wr_o`  out  1  1-cycle pulse at the end of every DIGITIZE frame with an in-range buffer.
- `event_id_ok_o`  out  1  parity result, qualified by `event_id_wr_o`; held until the next write.
- `event_id_buffer_o`  out  BUF_BITS  buffer index of the last DIGITIZE; held.
- `event_id_o`  out  ID_WIDTH  event ID of the last DIGITIZE; held.
- `frame_err_o`  out  1  1-cycle pulse on any frame error.
- `err_count_o`  out  8  saturating frame-error count (stops at 255).

## Operation
- **Frame format** (MSB first): start bit `1`; TYPE[1:0]; then a type-dependent payload.
  - TYPE 00 SAMPLE: no payload.
  - TYPE 01 DIGITIZE: BUF[BUF_BITS], ID[ID_WIDTH], then one even-parity bit over BUF and ID.
  - TYPE 10 CLEAR: BUF[BUF_BITS].
  - TYPE 11: reserved.
- **FSM states:** IDLE, TYPE, BUF, ID, PAR.
  - IDLE → TYPE on `cmd_i=1`.
  - TYPE (2 bits): 00 → emit SAMPLE, return to IDLE; 01/10 → BUF; 11 → frame error, return to IDLE.
  - BUF (BUF_BITS bits): CLEAR → emit, return to IDLE; DIGITIZE → ID.
  - ID (ID_WIDTH bits) → PAR.
  - PAR (1 bit) → IDLE.
- A single bit counter and shift register serve all payload fields. The counter reloads on each state entry and is sized `clog2(ID_WIDTH+1)`.
- **DIGITIZE with parity OK:**
  - `digitize_o[BUF]=1`.
  - `event_id_wr_o=1`, `event_id_ok_o=1`.
  - `event_id_o` and `event_id_buffer_o` update.
- **DIGITIZE with bad parity:**
  - `event_id_wr_o=1`, `event_id_ok_o=0`; ID and buffer still update.
  - No `digitize_o` pulse.
  - `frame_err_o` pulses and `err_count_o` increments.
- **Out-of-range buffer** (BUF ≥ NUM_BUFFERS, only possible when NUM_BUFFERS is not a power of 2):
  - DIGITIZE: evaluated at PAR; no `digitize_o`, no `event_id_wr_o`; held outputs do not update.
  - CLEAR: evaluated at end of BUF; no `clear_o`.
  - Both cases: frame error.
- **Reserved TYPE:** frame error, return to IDLE. A line still high in IDLE is taken as a new start bit; resynchronisation is the transmitter's responsibility.

## Timing
- Bit n of a frame is sampled on rising edge n (start bit = edge 0).
- All pulses are registered and go high after the edge that samples the frame's final bit, staying high for exactly one cycle. Add 1 cycle when `IN_REG=1`.
- Frame lengths: SAMPLE 3 cycles; CLEAR `3+BUF_BITS`; DIGITIZE `4+BUF_BITS+ID_WIDTH` (38 at defaults).
- **Back-to-back frames:** a start bit on the cycle immediately after a final bit is accepted; there is no dead cycle.
- **Reset values:** every output is 0 and the FSM is in IDLE.
- **Reset mid-frame:** the partial frame is discarded with no pulses, and `err_count_o` clears. After release, the first `cmd_i=1` is a start bit.

## Structure
- **Package `surf_cmd_pkg`:**
  - TYPE constants (`CMD_SAMPLE`, `CMD_DIGITIZE`, `CMD_CLEAR`, `CMD_RSVD`).
  - FSM state enum.
  - `clog2` function.
  - Shared with the v4 command interface, which generates the same frames.
- **Sub-module `surf_cmd_deser`:** bit counter plus shift register with load/shift/done. The FSM and output logic stay in the top-level module.

## Test plan
- **SAMPLE:** send `1,0,0` → `sample_o` pulses 1 cycle, exactly 3 cycles after the start edge; no other outputs.
- **Good DIGITIZE:** ID `0x12345678`, BUF 0, parity bit 1 → `digitize_o=0001`, `event_id_o=0x12345678`, `event_id_wr_o` and `event_id_ok_o`=1, 38 cycles after start.
- **Bad parity:** same frame with parity 0 → `event_id_wr_o=1`, `event_id_ok_o=0`, `digitize_o=0000`, `frame_err_o` pulse, `err_count_o=1`.
- **CLEAR then DIGITIZE back-to-back:** CLEAR BUF 3, then DIGITIZE ID `0xDEADBEEF` BUF 2 with no gap → `clear_o=1000`, then `digitize_o=0100`.
- **Reserved and saturation:** 300 frames of type 11 → `err_count_o=255`; reset mid-DIGITIZE (after 20 bits) → no pulses, all outputs 0.
- **Parameter variant:** `NUM_BUFFERS=3`, `ID_WIDTH=16`, `IN_REG=1`; DIGITIZE BUF 3 → frame error, no write; BUF 1 → `digitize_o=010` after a 22-cycle frame plus 1 cycle of latency.
